// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions for the pipelined control unit.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_ITYPE  = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       aluSrc;
    logic [1:0] aluOp;
    logic       branch;
    logic       jump;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       memToReg;
    logic       link;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode -> control bundle (valid left 0) plus illegal flag.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  output ctrl_bundle_t ctrl,
  output logic         illegal
);

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    illegal = 1'b0;
    unique case (opcode)
      OP_R: begin
        ctrl.aluOp    = ALU_RTYPE;
        ctrl.regWrite = 1'b1;
      end
      OP_IMM: begin
        ctrl.aluSrc   = 1'b1;
        ctrl.aluOp    = ALU_ITYPE;
        ctrl.regWrite = 1'b1;
      end
      OP_LOAD: begin
        ctrl.aluSrc   = 1'b1;
        ctrl.aluOp    = ALU_ADD;
        ctrl.memRead  = 1'b1;
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = 1'b1;
      end
      OP_STORE: begin
        ctrl.aluSrc   = 1'b1;
        ctrl.aluOp    = ALU_ADD;
        ctrl.memWrite = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.aluOp    = ALU_BRANCH;
        ctrl.branch   = 1'b1;
      end
      OP_JALR: begin
        ctrl.aluSrc   = 1'b1;
        ctrl.aluOp    = ALU_ADD;
        ctrl.jump     = 1'b1;
        ctrl.regWrite = 1'b1;
        ctrl.link     = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined main control: decode in ID, carry bundles through ID/EX, EX/MEM, MEM/WB.
// Load-use hazard detection and bubble counting exist only with PIPE_HAZARD_DETECT_EN.
module pipe_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int BUBBLE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [6:0]              id_opcode,
  input  logic [REG_ADDR_W-1:0]   id_rs1,
  input  logic [REG_ADDR_W-1:0]   id_rs2,
  input  logic [REG_ADDR_W-1:0]   id_rd,
  input  logic                    flush,
  input  logic                    ext_stall,
  output logic                    pc_write,
  output logic                    ifid_write,
  output logic                    id_illegal,
  output logic                    ex_valid,
  output logic                    ex_alu_src,
  output logic                    ex_branch,
  output logic                    ex_jump,
  output logic [1:0]              ex_alu_op,
  output logic [REG_ADDR_W-1:0]   ex_rd,
  output logic                    mem_valid,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    wb_valid,
  output logic                    wb_reg_write,
  output logic                    wb_mem_to_reg,
  output logic                    wb_link,
  output logic [REG_ADDR_W-1:0]   wb_rd,
  output logic [BUBBLE_CNT_W-1:0] bubble_count
);

  ctrl_bundle_t decCtrl, idCtrl, exCtrl, memCtrl, wbCtrl;
  logic [REG_ADDR_W-1:0] exRd, memRd, wbRd;
  logic decIllegal, hazard;

  ctrl_decode uDecode (
    .opcode  (id_opcode),
    .ctrl    (decCtrl),
    .illegal (decIllegal)
  );

  // Writes to x0 are architectural no-ops, so never request them.
  always_comb begin
    idCtrl       = decCtrl;
    idCtrl.valid = id_valid;
    if (id_rd == '0) idCtrl.regWrite = 1'b0;
  end

  assign id_illegal = id_valid & decIllegal;

`ifdef PIPE_HAZARD_DETECT_EN
  logic [BUBBLE_CNT_W-1:0] bubbleCnt;

  assign hazard = exCtrl.valid & exCtrl.memRead & (exRd != '0) & id_valid &
                  ((exRd == id_rs1) | (exRd == id_rs2));

  // A flush already bubbles ID/EX, so a simultaneous hazard costs nothing extra.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubbleCnt <= '0;
    end else if (!ext_stall && !flush && hazard && (bubbleCnt != '1)) begin
      bubbleCnt <= bubbleCnt + 1'b1;
    end
  end

  assign bubble_count = bubbleCnt;
`else
  logic unusedRs;

  assign unusedRs     = ^{id_rs1, id_rs2};
  assign hazard       = 1'b0;
  assign bubble_count = '0;
`endif

  assign pc_write   = rst | ~(ext_stall | (hazard & ~flush));
  assign ifid_write = pc_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exCtrl  <= CTRL_BUBBLE;
      exRd    <= '0;
      memCtrl <= CTRL_BUBBLE;
      memRd   <= '0;
      wbCtrl  <= CTRL_BUBBLE;
      wbRd    <= '0;
    end else if (!ext_stall) begin
      // ID/EX boundary
      if (flush || hazard) begin
        exCtrl <= CTRL_BUBBLE;
        exRd   <= '0;
      end else begin
        exCtrl <= idCtrl;
        exRd   <= id_rd;
      end
      // EX/MEM and MEM/WB boundaries
      memCtrl <= exCtrl;
      memRd   <= exRd;
      wbCtrl  <= memCtrl;
      wbRd    <= memRd;
    end
  end

  assign ex_valid      = exCtrl.valid;
  assign ex_alu_src    = exCtrl.aluSrc;
  assign ex_branch     = exCtrl.branch;
  assign ex_jump       = exCtrl.jump;
  assign ex_alu_op     = exCtrl.aluOp;
  assign ex_rd         = exRd;
  assign mem_valid     = memCtrl.valid;
  assign mem_read      = memCtrl.memRead;
  assign mem_write     = memCtrl.memWrite;
  assign wb_valid      = wbCtrl.valid;
  assign wb_reg_write  = wbCtrl.regWrite;
  assign wb_mem_to_reg = wbCtrl.memToReg;
  assign wb_link       = wbCtrl.link;
  assign wb_rd         = wbRd;

endmodule
